// File: rtl/lcra_seq_adder_ctrl_if.sv
// Request/result bundle for lcra_seq_adder_ctrl: operand handshake in, result handshake out.
// Optional macro LCRA_SUB_EN adds the sub_in request field.
interface lcra_seq_adder_ctrl_if #(
    parameter int WORDS = 4
);
    localparam int W = 16 * WORDS;

    logic         start_in;
    logic         ready_out;
    logic [W-1:0] A_in;
    logic [W-1:0] B_in;
    logic         C_in;
`ifdef LCRA_SUB_EN
    logic         sub_in;
`endif
    logic [W-1:0] S_out;
    logic         C_out;
    logic         OVF_out;
    logic         valid_out;
    logic         ready_in;
    logic         busy_out;

`ifdef LCRA_SUB_EN
    modport master (
        output start_in, A_in, B_in, C_in, sub_in, ready_in,
        input  ready_out, S_out, C_out, OVF_out, valid_out, busy_out
    );
    modport slave (
        input  start_in, A_in, B_in, C_in, sub_in, ready_in,
        output ready_out, S_out, C_out, OVF_out, valid_out, busy_out
    );
`else
    modport master (
        output start_in, A_in, B_in, C_in, ready_in,
        input  ready_out, S_out, C_out, OVF_out, valid_out, busy_out
    );
    modport slave (
        input  start_in, A_in, B_in, C_in, ready_in,
        output ready_out, S_out, C_out, OVF_out, valid_out, busy_out
    );
`endif
endinterface

// File: rtl/lcra_seq_adder_ctrl.sv
// Multi-word adder sequencer: one shared 16-bit Ling ripple slice, LSB slice first, carry chained in a register.
// Optional macro LCRA_SUB_EN enables subtract mode (B inverted, carry-in inverted).
module LCRA_16 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        C_in,
    output logic [15:0] S,
    output logic        C_out,
    output logic        G_out,
    output logic        P_out
);
    logic [15:0] g;
    logic [15:0] t;
    logic        c;
    logic        cg;
    logic        h;
    logic        hg;

    assign g = A & B;
    assign t = A | B;

    // Ling pseudo-carry h = g | c; the true carry out of bit i is t[i] & h.
    always_comb begin
        S  = '0;
        c  = C_in;
        cg = 1'b0;
        h  = 1'b0;
        hg = 1'b0;
        for (int i = 0; i < 16; i++) begin
            S[i] = A[i] ^ B[i] ^ c;
            h    = g[i] | c;
            hg   = g[i] | cg;
            c    = t[i] & h;
            cg   = t[i] & hg;
        end
        C_out = c;
        G_out = cg;
        P_out = &t;
    end
endmodule

module lcra_seq_adder_ctrl #(
    parameter int WORDS = 4
) (
    input logic                 clk_in,
    input logic                 rst_n_in,
    lcra_seq_adder_ctrl_if.slave bus
);
    localparam int W  = 16 * WORDS;
    localparam int KW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  s_q, s_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic          ready;
    logic          valid;
    logic          busy;
    logic [W-1:0]  b_prep;
    logic          c_prep;
    logic [15:0]   slice_a;
    logic [15:0]   slice_b;
    logic [15:0]   slice_s;
    logic          slice_c;
    logic          lcra_g_unused;
    logic          lcra_p_unused;

`ifdef LCRA_SUB_EN
    assign b_prep = bus.sub_in ? ~bus.B_in : bus.B_in;
    assign c_prep = bus.sub_in ? ~bus.C_in : bus.C_in;
`else
    assign b_prep = bus.B_in;
    assign c_prep = bus.C_in;
`endif

    assign slice_a = a_q[{k_q, 4'b0000} +: 16];
    assign slice_b = b_q[{k_q, 4'b0000} +: 16];

    LCRA_16 u_lcra (
        .A     (slice_a),
        .B     (slice_b),
        .C_in  (carry_q),
        .S     (slice_s),
        .C_out (slice_c),
        .G_out (lcra_g_unused),
        .P_out (lcra_p_unused)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        ready   = 1'b0;
        valid   = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.start_in) begin
                    a_d     = bus.A_in;
                    b_d     = b_prep;
                    carry_d = c_prep;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy                      = 1'b1;
                s_d[{k_q, 4'b0000} +: 16] = slice_s;
                carry_d                   = slice_c;
                k_d                       = k_q + 1'b1;
                if (k_q == KW'(WORDS - 1)) begin
                    cout_d  = slice_c;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_s[15] != a_q[W-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                busy  = 1'b1;
                valid = 1'b1;
                if (bus.ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latched operands need no reset: they are always reloaded on accept before use.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
        a_q <= a_d;
        b_q <= b_d;
    end

    assign bus.ready_out = ready;
    assign bus.valid_out = valid;
    assign bus.busy_out  = busy;
    assign bus.S_out     = s_q;
    assign bus.C_out     = cout_q;
    assign bus.OVF_out   = ovf_q;
endmodule

// File: tb/tb_lcra_seq_adder_ctrl.sv
// Randomized self-checking bench for lcra_seq_adder_ctrl against an integer-arithmetic reference model.
module tb_lcra_seq_adder_ctrl;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;
    localparam logic signed [W+1:0] MAXS = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MINS = {3'b111, {(W-1){1'b0}}};

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         ovf;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lcra_seq_adder_ctrl_if #(.WORDS(WORDS)) bus ();

    lcra_seq_adder_ctrl #(.WORDS(WORDS)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: exact integer sum/difference; carry = no unsigned wrap (no borrow when subtracting).
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic signed [W+1:0] sa, sb, sc, exact;
        logic [W:0]          wide;
        res_t                r;
        sa = $signed({{2{a[W-1]}}, a});
        sb = $signed({{2{b[W-1]}}, b});
        sc = $signed({{(W+1){1'b0}}, cin});
        if (sub) begin
            r.s   = a - b - W'(cin);
            r.c   = ({1'b0, a} >= ({1'b0, b} + (W+1)'(cin)));
            exact = sa - sb - sc;
        end else begin
            wide  = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            r.s   = wide[W-1:0];
            r.c   = wide[W];
            exact = sa + sb + sc;
        end
        r.ovf = (exact > MAXS) || (exact < MINS);
        return r;
    endfunction

    function automatic logic [W-1:0] rnd64();
        logic [W-1:0] v;
        v = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: v = '1;
            1: v = {1'b0, {(W-1){1'b1}}};
            2: v = {1'b1, {(W-1){1'b0}}};
            3: v = '0;
            default: ;
        endcase
        return v;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input int hold, input string tag);
        res_t exp;
        int   n;
        exp = model(a, b, cin, sub);
        n = 0;
        while (!bus.ready_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready_out) begin
            chk({tag, "_ready_timeout"}, 0, 1);
            return;
        end
        bus.A_in     = a;
        bus.B_in     = b;
        bus.C_in     = cin;
`ifdef LCRA_SUB_EN
        bus.sub_in   = sub;
`endif
        bus.start_in = 1'b1;
        @(negedge clk);
        // Scramble the operand inputs: only the latched copies may be used.
        bus.start_in = 1'b0;
        bus.A_in     = {$urandom(), $urandom()};
        bus.B_in     = {$urandom(), $urandom()};
        bus.C_in     = $urandom_range(0, 1);
        bus.ready_in = $urandom_range(0, 1);
        n = 1;
        while (!bus.valid_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, WORDS + 1);
        if (!bus.valid_out) return;
        chk({tag, "_S"}, bus.S_out, exp.s);
        chk({tag, "_C"}, bus.C_out, exp.c);
        chk({tag, "_OVF"}, bus.OVF_out, exp.ovf);
        chk({tag, "_busy"}, bus.busy_out, 1);
        chk({tag, "_rdy_lo"}, bus.ready_out, 0);
        for (int i = 0; i < hold; i++) begin
            bus.ready_in = 1'b0;
            bus.start_in = ~bus.start_in;
            bus.A_in     = {$urandom(), $urandom()};
            @(negedge clk);
            chk({tag, "_hold_S"}, bus.S_out, exp.s);
            chk({tag, "_hold_v"}, bus.valid_out, 1);
            chk({tag, "_hold_rdy"}, bus.ready_out, 0);
        end
        bus.start_in = 1'b0;
        bus.ready_in = 1'b1;
        @(negedge clk);
        bus.ready_in = 1'b0;
        chk({tag, "_post_v"}, bus.valid_out, 0);
        chk({tag, "_post_rdy"}, bus.ready_out, 1);
        chk({tag, "_post_busy"}, bus.busy_out, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_valid;
        bus.start_in = 1'b0;
        bus.A_in     = '0;
        bus.B_in     = '0;
        bus.C_in     = 1'b0;
        bus.ready_in = 1'b0;
`ifdef LCRA_SUB_EN
        bus.sub_in   = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.ready_out, 1);
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_busy", bus.busy_out, 0);
        chk("rst_S", bus.S_out, 0);
        chk("rst_C", bus.C_out, 0);
        chk("rst_OVF", bus.OVF_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 4, "slice_carry");
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0, "ripple");
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1, "sovf");
`ifdef LCRA_SUB_EN
        run_op(64'h5, 64'h7, 1'b0, 1'b1, 0, "sub");
`endif

        // Abort: reset asserted during the second RUN cycle.
        bus.A_in     = 64'h1234_5678_9ABC_DEF0;
        bus.B_in     = 64'h0FED_CBA9_8765_4321;
        bus.C_in     = 1'b1;
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ready", bus.ready_out, 1);
        chk("abort_valid", bus.valid_out, 0);
        chk("abort_busy", bus.busy_out, 0);
        chk("abort_S", bus.S_out, 0);
        chk("abort_C", bus.C_out, 0);
        chk("abort_OVF", bus.OVF_out, 0);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < WORDS + 3; i++) begin
            @(negedge clk);
            if (bus.valid_out) seen_valid = 1'b1;
        end
        chk("abort_no_valid", seen_valid, 0);

        for (int i = 0; i < 40; i++) begin
            logic sub;
            sub = 1'b0;
`ifdef LCRA_SUB_EN
            sub = $urandom_range(0, 1);
`endif
            run_op(rnd64(), rnd64(), $urandom_range(0, 1), sub, $urandom_range(0, 3), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcra_seq_adder_ctrl.md
# lcra_seq_adder_ctrl

Sequencing controller that performs wide multi-word additions (optionally subtractions) by time-multiplexing one 16-bit Ling ripple adder slice (`LCRA_16`). It latches a full-width operand pair under a valid/ready handshake. It then feeds one 16-bit slice per cycle through the shared adder, least-significant first, chaining the carry through a register. The finished result is presented under a second valid/ready handshake. It sits between a requester wanting 16·WORDS-bit arithmetic and the single `LCRA_16` instance it owns.

## Interface
- `WORDS`, 4, number of 16-bit slices; operand width W = 16·WORDS; legal range 2..16.

Ports:
- `clk_in` in 1: single clock, rising edge.
- `rst_n_in` in 1: synchronous, active-low reset.
- `start_in` in 1: request valid.
- `ready_out` out 1: controller can accept a request (high only in IDLE).
- `A_in` in W: operand A, sampled on accept.
- `B_in` in W: operand B, sampled on accept.
- `C_in` in 1: carry-in (borrow-in when subtracting), sampled on accept.
- `sub_in` in 1: 1 = subtract; sampled on accept. Present only with `LCRA_SUB_EN`.
- `S_out` out W: result, stable while `valid_out` is high.
- `C_out` out 1: final carry out of the top slice.
- `OVF_out` out 1: two's-complement signed overflow of the full-width result.
- `valid_out` out 1: result valid.
- `ready_in` in 1: consumer accepts the result.
- `busy_out` out 1: high in RUN and DONE.

## Operation
- FSM states:
  - IDLE:
    - `ready_out`=1.
    - On `start_in`=1, latch A, B, C_in (and sub_in).
    - Clear the slice index k to 0, load the carry register with the initial carry, then go to RUN.
  - RUN:
    - Drive the adder with A[16k+15:16k], B'[16k+15:16k] and the carry register.
    - Register the adder sum into S[16k+15:16k] and the adder `C_out` into the carry register, then increment k.
    - When k = WORDS-1, go to DONE after this edge.
  - DONE:
    - `valid_out`=1.
    - Hold S, C_out and OVF until `ready_in`=1, then go to IDLE on that edge.
- Operand and carry preparation:
  - Add mode: B' = B, initial carry = C_in.
  - Subtract mode (`LCRA_SUB_EN` only): B' = ~B, initial carry = ~C_in. This gives S = A − B − C_in mod 2^W. `C_out`=1 means no borrow.
- `C_out` = carry register after the last slice.
- `OVF_out` = (A[W-1] == B'[W-1]) && (S[W-1] != A[W-1]). Computed on the last RUN edge.
- Result width is exactly W; the carry never wraps into S.
- The adder's own `G_out`/`P_out` outputs are left unconnected.
- `start_in` while not in IDLE is ignored, with no queuing. The requester must hold `start_in` until it sees `ready_out`.
- Operand inputs may change freely after the accept edge; the latched copies are used.

## Timing
- Accept edge = rising edge with `start_in`=1 and `ready_out`=1; call it edge 0.
- RUN occupies cycles 1..WORDS. `valid_out` rises after edge WORDS, so latency is WORDS+1 cycles from accept to result valid (5 for WORDS=4).
- `valid_out` stays high until the edge where `ready_in`=1. `ready_out` goes high on the following cycle.
- There is no accept in the same cycle as result hand-off. Minimum request spacing is WORDS+2 cycles.
- Reset values, held while `rst_n_in`=0:
  - State IDLE, `ready_out`=1, `valid_out`=0, `busy_out`=0.
  - `S_out`=0, `C_out`=0, `OVF_out`=0.
  - k=0, carry register=0.
- Reset asserted mid-RUN or in DONE aborts the operation: no `valid_out` pulse, and all outputs return to reset values on that edge.
- `ready_in` high outside DONE has no effect.

## Configuration
- `LCRA_SUB_EN` defined: the `sub_in` port exists and subtract mode is supported as described.
- `LCRA_SUB_EN` undefined: there is no `sub_in` port and the block is add-only, with B' = B and initial carry = C_in. The B-inversion logic is not synthesized.

## Test plan
- Reset: hold `rst_n_in`=0 for 3 cycles → `ready_out`=1, `valid_out`=0, `S_out`=0, `C_out`=0, `OVF_out`=0.
- Slice-boundary carry (WORDS=4): A=0x0000_0000_0000_FFFF, B=0x1, C_in=0 → S=0x0000_0000_0001_0000, `C_out`=0, `OVF_out`=0. `valid_out` rises exactly 5 cycles after accept.
- Full carry ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0, C_in=1 → S=0, `C_out`=1, `OVF_out`=0.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, C_in=0 → S=0x8000_0000_0000_0000, `OVF_out`=1, `C_out`=0.
- Back-pressure and abort:
  - Hold `ready_in`=0 for 4 cycles in DONE while pulsing `start_in` → S stays stable and the new request is not accepted; `ready_out` returns 1 cycle after `ready_in`=1.
  - Separately, assert `rst_n_in`=0 during RUN cycle 2 → no `valid_out` pulse and all outputs zero.
- Subtract (with `LCRA_SUB_EN`): `sub_in`=1, A=5, B=7, C_in=0 → S=0xFFFF_FFFF_FFFF_FFFE, `C_out`=0, `OVF_out`=0.
